// File: rtl/mmap_read_arbiter.sv
// Round-robin read arbiter: merges per-port read-address streams into one downstream
// engine and routes in-order responses back to the requester recorded in a tag FIFO.
module mmap_read_arbiter #(
    parameter int NumPorts    = 4,
    parameter int PortIdWidth = 2,
    parameter int AddrWidth   = 64,
    parameter int DataWidth   = 512,
    parameter int TagDepth    = 64,
    parameter int TagDepthLog = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
    input  logic [NumPorts-1:0]           req_addr_write,
    output logic [NumPorts-1:0]           req_addr_full_n,
    output logic [DataWidth-1:0]          resp_data_dout,
    output logic [NumPorts-1:0]           resp_empty_n,
    input  logic [NumPorts-1:0]           resp_read,
    output logic [AddrWidth-1:0]          read_addr_din,
    output logic                          read_addr_write,
    input  logic                          read_addr_full_n,
    input  logic [DataWidth-1:0]          read_data_dout,
    output logic                          read_data_read,
    input  logic                          read_data_empty_n
);

    localparam logic [TagDepthLog:0]   TagFull  = (TagDepthLog + 1)'(TagDepth);
    localparam logic [TagDepthLog-1:0] PtrLast  = TagDepthLog'(TagDepth - 1);
    localparam logic [PortIdWidth-1:0] PortLast = PortIdWidth'(NumPorts - 1);

    logic [NumPorts-1:0]    buf_valid_q, buf_valid_d;
    logic [AddrWidth-1:0]   buf_addr_q [NumPorts];
    logic [PortIdWidth-1:0] rr_ptr_q, rr_ptr_d;

    logic [PortIdWidth-1:0] tag_mem_q [TagDepth];
    logic [TagDepthLog-1:0] tag_wr_q, tag_wr_d;
    logic [TagDepthLog-1:0] tag_rd_q, tag_rd_d;
    logic [TagDepthLog:0]   tag_count_q, tag_count_d;

    logic [PortIdWidth-1:0] grant;
    logic [PortIdWidth-1:0] cand;
    logic                   grant_found;
    logic                   issue_any;
    logic [NumPorts-1:0]    issue;
    logic [NumPorts-1:0]    push;
    logic [PortIdWidth-1:0] tag_head;
    logic                   head_ready;
    logic                   tag_push;
    logic                   tag_pop;

    function automatic logic [TagDepthLog-1:0] tag_ptr_next(input logic [TagDepthLog-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PortIdWidth-1:0] port_next(input logic [PortIdWidth-1:0] p);
        return (p == PortLast) ? '0 : p + 1'b1;
    endfunction

    // First valid buffer at or after rr_ptr, wrapping modulo NumPorts.
    always_comb begin
        grant       = rr_ptr_q;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NumPorts; k++) begin
            cand = PortIdWidth'((int'(rr_ptr_q) + k) % NumPorts);
            if (!grant_found && buf_valid_q[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign read_addr_write = grant_found && (tag_count_q < TagFull);
    assign read_addr_din   = buf_addr_q[grant];
    assign issue_any       = read_addr_write && read_addr_full_n;

    // A buffer that issues this cycle can be refilled in the same cycle.
    always_comb begin
        issue           = '0;
        req_addr_full_n = '0;
        push            = '0;
        buf_valid_d     = buf_valid_q;
        for (int i = 0; i < NumPorts; i++) begin
            issue[i]           = issue_any && (grant == PortIdWidth'(i));
            req_addr_full_n[i] = !buf_valid_q[i] || issue[i];
            push[i]            = req_addr_write[i] && req_addr_full_n[i];
            buf_valid_d[i]     = push[i] || (buf_valid_q[i] && !issue[i]);
        end
    end

    assign rr_ptr_d = issue_any ? port_next(grant) : rr_ptr_q;

    assign tag_head   = tag_mem_q[tag_rd_q];
    assign head_ready = read_data_empty_n && (tag_count_q != '0);

    always_comb begin
        resp_empty_n = '0;
        for (int i = 0; i < NumPorts; i++) begin
            resp_empty_n[i] = head_ready && (tag_head == PortIdWidth'(i));
        end
    end

    assign read_data_read = head_ready && resp_read[tag_head];
    assign resp_data_dout = read_data_dout;

    assign tag_push = issue_any;
    assign tag_pop  = read_data_read;

    always_comb begin
        tag_wr_d    = tag_push ? tag_ptr_next(tag_wr_q) : tag_wr_q;
        tag_rd_d    = tag_pop  ? tag_ptr_next(tag_rd_q) : tag_rd_q;
        tag_count_d = tag_count_q;
        case ({tag_push, tag_pop})
            2'b10:   tag_count_d = tag_count_q + 1'b1;
            2'b01:   tag_count_d = tag_count_q - 1'b1;
            default: tag_count_d = tag_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            tag_count_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_count_q <= tag_count_d;
        end
    end

    // Storage only; its contents are qualified by the valid bits and tag_count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumPorts; i++) begin
            if (push[i]) begin
                buf_addr_q[i] <= req_addr_din[i*AddrWidth +: AddrWidth];
            end
        end
        if (tag_push) begin
            tag_mem_q[tag_wr_q] <= grant;
        end
    end

endmodule
